// File: rtl/marquee_scroller.sv
// Scrolling ASCII marquee for a multiplexed 16-segment display: message buffer, digit refresh and scroll offset.
// Define MARQUEE_PAD_EN to append NUM_DIGITS virtual trailing spaces so the text scrolls fully off before repeating.
module marquee_scroller #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH  = 32,
  parameter int MUX_DIV    = 1000,
  parameter int SCROLL_DIV = 12_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       msg_valid,
  input  logic [7:0]                 msg_data,
  output logic                       msg_ready,
  input  logic                       msg_clear,
  input  logic                       run,
  output logic [$clog2(MSG_DEPTH):0] msg_len,
  output logic [7:0]                 ascii,
  output logic [NUM_DIGITS-1:0]      digit_an,
  output logic                       scroll_wrap
);
  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int LW = $clog2(MSG_DEPTH) + 1;
  localparam int VW = $clog2(MSG_DEPTH + 2 * NUM_DIGITS) + 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MW = $clog2(MUX_DIV);
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
`ifdef MARQUEE_PAD_EN
  localparam int PAD = NUM_DIGITS;
`else
  localparam int PAD = 0;
`endif

  localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(MSG_DEPTH);

  logic [7:0]    mem [MSG_DEPTH];
  logic [MW-1:0] mux_cnt;
  logic [DW-1:0] d;
  logic [SW-1:0] scr_cnt;
  logic          pending;
  logic [VW-1:0] offset;

  logic [VW-1:0] vlen, off_inc, sum, idx;
  logic          mux_tc, frame_end, scroll_en, step, append, in_range;
  logic [7:0]    char_d;

  assign msg_ready = msg_len < DEPTH_L;

  always_comb begin
    vlen      = VW'(msg_len) + VW'(PAD);
    mux_tc    = (mux_cnt == MUX_LAST);
    frame_end = mux_tc && (d == D_LAST);
    scroll_en = run && (msg_len != '0);
    step      = scroll_en && (scr_cnt == SCR_LAST);
    append    = msg_valid && msg_ready && !msg_clear;
    in_range  = offset < vlen;
    off_inc   = offset + VW'(1);
    sum       = offset + VW'(d);
    // vlen can be smaller than NUM_DIGITS, so a plain wrap-once is not enough here
    idx       = (vlen == '0) ? '0 : sum % vlen;
    char_d    = 8'h20;
    if (idx < VW'(msg_len)) char_d = mem[idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst_n && append) mem[msg_len[AW-1:0]] <= msg_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_len     <= '0;
      offset      <= '0;
      pending     <= 1'b0;
      d           <= '0;
      mux_cnt     <= '0;
      scr_cnt     <= '0;
      ascii       <= 8'h20;
      digit_an    <= '1;
      scroll_wrap <= 1'b0;
    end else begin
      scroll_wrap <= 1'b0;
      mux_cnt     <= mux_tc ? '0 : mux_cnt + MW'(1);
      if (mux_tc) d <= (d == D_LAST) ? '0 : d + DW'(1);
      // Outputs load once at slot start, so an append mid-slot shows from the next slot.
      if (mux_cnt == '0) begin
        ascii    <= char_d;
        digit_an <= ~(NUM_DIGITS'(1) << d);
      end
      if (msg_clear) begin
        msg_len <= '0;
        offset  <= '0;
        pending <= 1'b0;
        scr_cnt <= '0;
      end else begin
        if (append)    msg_len <= msg_len + LW'(1);
        if (scroll_en) scr_cnt <= step ? '0 : scr_cnt + SW'(1);
        if (frame_end && !in_range) begin
          offset <= '0;
        end else if (frame_end && pending) begin
          if (off_inc == vlen) begin
            offset      <= '0;
            scroll_wrap <= 1'b1;
          end else begin
            offset <= off_inc;
          end
        end
        pending <= step || (pending && !(frame_end && in_range));
      end
    end
  end
endmodule
